// File: rtl/dual_issue_queue_if.sv
// -----------------------------------------------------------------------------
// dual_issue_queue_if
//   Bundles the fetch-side and decode-side signals of the dual-issue
//   instruction queue.
//   master : fetch/decode pipeline control (drives F inputs, StallD, Flush)
//   slave  : the queue itself (drives FetchReady, decode slots, Count)
//   Signals:
//     InstrF1/InstrF2/PCF/ValidF1/ValidF2 : fetched pair, InstrF2 at PCF+4
//     FetchReady                          : room for two more instructions
//     StallD / Flush                      : decode hold / discard everything
//     InstrD1/2, PCD1/2, ValidD1/2        : registered decode slots
//     Count                               : current queue occupancy
// -----------------------------------------------------------------------------
interface dual_issue_queue_if #(
    parameter int DEPTH = 8,
    parameter int IW    = 32,
    parameter int PW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [IW-1:0] InstrF1;
    logic [IW-1:0] InstrF2;
    logic [PW-1:0] PCF;
    logic          ValidF1;
    logic          ValidF2;
    logic          FetchReady;
    logic          StallD;
    logic          Flush;
    logic [IW-1:0] InstrD1;
    logic [IW-1:0] InstrD2;
    logic [PW-1:0] PCD1;
    logic [PW-1:0] PCD2;
    logic          ValidD1;
    logic          ValidD2;
    logic [CW-1:0] Count;

    modport master (
        output InstrF1, InstrF2, PCF, ValidF1, ValidF2, StallD, Flush,
        input  FetchReady, InstrD1, InstrD2, PCD1, PCD2, ValidD1, ValidD2, Count
    );

    modport slave (
        input  InstrF1, InstrF2, PCF, ValidF1, ValidF2, StallD, Flush,
        output FetchReady, InstrD1, InstrD2, PCD1, PCD2, ValidD1, ValidD2, Count
    );
endinterface

// File: rtl/dual_issue_queue.sv
// -----------------------------------------------------------------------------
// dual_issue_queue
//   Instruction buffer plus IF/ID register for the two-wide front end.
//   Up to two fetched instructions are written per cycle into a circular
//   queue; each unstalled cycle the oldest one or two entries are moved into
//   the decode slots, pairing them only when the pair is hazard-free.
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     q_if   : dual_issue_queue_if.slave (fetch pair, stall/flush, D slots)
// -----------------------------------------------------------------------------
module dual_issue_queue #(
    parameter int DEPTH = 8,
    parameter int IW    = 32,
    parameter int PW    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    dual_issue_queue_if.slave  q_if
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Pairing-relevant view of one instruction.
    typedef struct packed {
        logic       has_dst;
        logic [4:0] dst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       is_mem;
        logic       is_ctrl;
    } dec_t;

    // Only bits [31:11] (opcode and register fields) matter for pairing.
    function automatic dec_t decode(input logic [31:11] f);
        dec_t       d;
        logic [5:0] op;
        op        = f[31:26];
        d         = '0;
        d.rs      = f[25:21];
        d.rt      = f[20:16];
        if (op == 6'h00)
            d.dst = f[15:11];
        else if (op inside {6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23})
            d.dst = f[20:16];
        // Writes to register 0 are architecturally discarded.
        d.has_dst = (d.dst != 5'd0);
        d.uses_rt = op inside {6'h00, 6'h2B, 6'h04, 6'h05};
        d.is_mem  = op inside {6'h23, 6'h2B};
        d.is_ctrl = op inside {6'h02, 6'h04, 6'h05};
        return d;
    endfunction

    logic [IW-1:0] r_instr [DEPTH];
    logic [PW-1:0] r_pc    [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic [IW-1:0] r_instr_d1, r_instr_d2;
    logic [PW-1:0] r_pc_d1, r_pc_d2;
    logic          r_valid_d1, r_valid_d2;

    logic [AW-1:0] w_head1;
    logic [AW-1:0] w_tail1;
    dec_t          w_dec_a;
    dec_t          w_dec_b;
    logic          w_illegal;
    logic          w_fetch_ready;
    logic          w_enq1;
    logic          w_enq2;
    logic [1:0]    w_n_enq;
    logic [1:0]    w_n_iss;

    // Power-of-two depth: pointer arithmetic wraps for free.
    assign w_head1 = r_head + AW'(1);
    assign w_tail1 = r_tail + AW'(1);

    assign w_dec_a = decode(r_instr[r_head][31:11]);
    assign w_dec_b = decode(r_instr[w_head1][31:11]);

    assign w_illegal =
        (w_dec_a.has_dst && ((w_dec_b.rs == w_dec_a.dst) ||
                             (w_dec_b.uses_rt && (w_dec_b.rt == w_dec_a.dst)))) ||
        (w_dec_a.has_dst && w_dec_b.has_dst && (w_dec_b.dst == w_dec_a.dst)) ||
        (w_dec_a.is_mem  && w_dec_b.is_mem) ||
        (w_dec_a.is_ctrl && w_dec_b.is_ctrl);

    // Registered occupancy only, so fetch never sees a same-cycle issue.
    assign w_fetch_ready = (r_count <= CW'(DEPTH - 2));

    assign w_enq1  = w_fetch_ready && q_if.ValidF1 && !q_if.Flush;
    assign w_enq2  = w_enq1 && q_if.ValidF2;
    assign w_n_enq = {1'b0, w_enq1} + {1'b0, w_enq2};

    always_comb begin
        // NOTE: default first so every path assigns it and no latch is inferred.
        w_n_iss = 2'd0;
        if (!q_if.StallD && !q_if.Flush) begin
            if (r_count == CW'(0))
                w_n_iss = 2'd0;
            else if ((r_count == CW'(1)) || w_illegal)
                w_n_iss = 2'd1;
            else
                w_n_iss = 2'd2;
        end
    end

    // NOTE: the storage array has no reset; Count gates which entries are live.
    always_ff @(posedge clk) begin
        if (w_enq1) begin
            r_instr[r_tail] <= q_if.InstrF1;
            r_pc[r_tail]    <= q_if.PCF;
        end
        if (w_enq2) begin
            r_instr[w_tail1] <= q_if.InstrF2;
            r_pc[w_tail1]    <= q_if.PCF + PW'(4);
        end
    end

    // NOTE: non-blocking assignments for all sequential state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (q_if.Flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_n_iss);
            r_tail  <= r_tail + AW'(w_n_enq);
            r_count <= r_count + CW'(w_n_enq) - CW'(w_n_iss);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_d1 <= 1'b0;
            r_valid_d2 <= 1'b0;
            r_instr_d1 <= '0;
            r_instr_d2 <= '0;
            r_pc_d1    <= '0;
            r_pc_d2    <= '0;
        end else if (q_if.Flush) begin
            r_valid_d1 <= 1'b0;
            r_valid_d2 <= 1'b0;
            r_instr_d1 <= '0;
            r_instr_d2 <= '0;
            r_pc_d1    <= '0;
            r_pc_d2    <= '0;
        end else if (!q_if.StallD) begin
            r_valid_d1 <= (w_n_iss != 2'd0);
            r_valid_d2 <= (w_n_iss == 2'd2);
            r_instr_d1 <= (w_n_iss != 2'd0) ? r_instr[r_head]  : '0;
            r_pc_d1    <= (w_n_iss != 2'd0) ? r_pc[r_head]     : '0;
            r_instr_d2 <= (w_n_iss == 2'd2) ? r_instr[w_head1] : '0;
            r_pc_d2    <= (w_n_iss == 2'd2) ? r_pc[w_head1]    : '0;
        end
    end

    assign q_if.FetchReady = w_fetch_ready;
    assign q_if.Count      = r_count;
    assign q_if.ValidD1    = r_valid_d1;
    assign q_if.ValidD2    = r_valid_d2;
    assign q_if.InstrD1    = r_instr_d1;
    assign q_if.InstrD2    = r_instr_d2;
    assign q_if.PCD1       = r_pc_d1;
    assign q_if.PCD2       = r_pc_d2;
endmodule
